// File: rtl/kernel_chan_bridge.sv
// Channel bridge around a stall-controlled kernel pipeline. Output FIFO space is
// reserved before an operand enters the kernel, so no kernel result is ever dropped.
module kernel_chan_bridge #(
   parameter int DATAW = 32,
   parameter int LAT   = 5,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data0,
   input  logic [DATAW-1:0] in_data1,
   output logic             k_stall,
   output logic [DATAW-1:0] k_vin0,
   output logic [DATAW-1:0] k_vin1,
   input  logic [DATAW-1:0] k_vout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(DEPTH + LAT + 1);

   logic [LAT-1:0]   vld_q, vld_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    wrPtr_q, rdPtr_q;
   logic [DATAW-1:0] mem_q [DEPTH];
   logic [RW-1:0]    reserved;
   logic             accept, advance, push, pop;

   // Every in-flight operand holds a FIFO slot, so occupancy plus in-flight must fit.
   always_comb begin
      reserved = RW'(cnt_q);
      for (int i = 0; i < LAT; i++) begin
         reserved = reserved + RW'(vld_q[i]);
      end
   end

   assign in_ready  = !rst && !stall_in && (reserved < RW'(DEPTH));
   assign accept    = in_valid && in_ready;
   assign advance   = !stall_in && (accept || (vld_q != '0));
   assign push      = advance && vld_q[LAT-1];
   assign pop       = out_valid && out_ready;
   assign k_stall   = !advance;
   assign k_vin0    = in_data0;
   assign k_vin1    = in_data1;
   assign out_valid = (cnt_q != '0);
   assign out_data  = mem_q[rdPtr_q];

   generate
      if (LAT == 1) begin : gShortPipe
         assign vld_d = advance ? accept : vld_q;
      end else begin : gLongPipe
         assign vld_d = advance ? {vld_q[LAT-2:0], accept} : vld_q;
      end
   endgenerate

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         cnt_q   <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
      end
   end

   // Storage carries no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= k_vout;
      end
   end

endmodule

// File: tb/tb_kernel_chan_bridge.sv
// Bench for kernel_chan_bridge: a stall-able adder stands in for the kernel, and a
// queue-based model of in-flight operands and buffered results checks every cycle.
module tb_kernel_chan_bridge;

   localparam int DATAW = 32;
   localparam int LAT   = 5;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall_in = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DATAW-1:0] in_data0 = '0;
   logic [DATAW-1:0] in_data1 = '0;
   logic             k_stall;
   logic [DATAW-1:0] k_vin0, k_vin1, k_vout;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [DATAW-1:0] out_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int baseCyc = 0;
   bit started = 1'b0;

   // Model state: in-flight ops count down remaining advances; fifoQ holds finished results.
   int          inflightRem[$];
   logic [31:0] inflightVal[$];
   logic [31:0] fifoQ[$];

   // Event logs from the DUT's own handshakes, read by the directed checks.
   int          accCyc[$];
   int          popCyc[$];
   logic [31:0] popDat[$];

   kernel_chan_bridge #(.DATAW(DATAW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data0(in_data0), .in_data1(in_data1),
      .k_stall(k_stall), .k_vin0(k_vin0), .k_vin1(k_vin1), .k_vout(k_vout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in kernel: LAT-stage adder that holds all stages while stalled.
   logic [DATAW-1:0] kPipe [LAT];
   always @(posedge clk) begin
      if (!k_stall) begin
         for (int i = LAT - 1; i > 0; i--) kPipe[i] <= kPipe[i-1];
         kPipe[0] <= k_vin0 + k_vin1;
      end
   end
   assign k_vout = kPipe[LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                                input logic rdy, input logic st);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data0  = d0;
      in_data1  = d1;
      out_ready = rdy;
      stall_in  = st;
   endtask

   task automatic clearLogs();
      accCyc.delete();
      popCyc.delete();
      popDat.delete();
   endtask

   // Per-cycle compare against the model, then advance the model to the next edge.
   always @(negedge clk) begin
      bit mIn, mAcc, mAdv, mPop;
      if (started && rst) begin
         inflightRem.delete();
         inflightVal.delete();
         fifoQ.delete();
         checkOutput("rst_in_ready", in_ready, 0);
         checkOutput("rst_out_valid", out_valid, 0);
         checkOutput("rst_k_stall", k_stall, 1);
      end else if (started) begin
         mIn  = !stall_in && ((fifoQ.size() + inflightVal.size()) < DEPTH);
         mAcc = in_valid && mIn;
         mAdv = !stall_in && (mAcc || inflightVal.size() != 0);
         mPop = (fifoQ.size() != 0) && out_ready;
         checkOutput("in_ready", in_ready, mIn);
         checkOutput("k_stall", k_stall, !mAdv);
         checkOutput("out_valid", out_valid, fifoQ.size() != 0);
         if (fifoQ.size() != 0) checkOutput("out_data", out_data, fifoQ[0]);
         checkOutput("k_vin0", k_vin0, in_data0);
         checkOutput("k_vin1", k_vin1, in_data1);
         checkOutput("occupancy", 32'(dut.cnt_q), fifoQ.size());
         if (!k_stall && dut.vld_q[LAT-1]) checkOutput("push_room", 32'(dut.cnt_q < DEPTH), 1);

         if (in_valid && in_ready) accCyc.push_back(cyc);
         if (out_valid && out_ready) begin
            popCyc.push_back(cyc);
            popDat.push_back(out_data);
         end

         if (mPop) void'(fifoQ.pop_front());
         if (mAdv) begin
            foreach (inflightRem[k]) inflightRem[k]--;
            if (inflightRem.size() != 0 && inflightRem[0] == 0) begin
               fifoQ.push_back(inflightVal[0]);
               void'(inflightRem.pop_front());
               void'(inflightVal.pop_front());
            end
         end
         if (mAcc) begin
            inflightRem.push_back(LAT);
            inflightVal.push_back(in_data0 + in_data1);
         end
      end
   end

   initial begin
      bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] expQ[$];

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      started = 1'b1;
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_k_stall", k_stall, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      baseCyc = cyc;

      // Single op accepted in cycle 10
      clearLogs();
      while (cyc - baseCyc < 9) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 3, 4, 1, 0);
      repeat (12) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("single_count", popDat.size(), 1);
      if (popDat.size() == 1 && accCyc.size() == 1) begin
         checkOutput("single_data", popDat[0], 7);
         checkOutput("single_latency", popCyc[0] - accCyc[0], 6);
         checkOutput("single_first_valid", popCyc[0] - baseCyc, 16);
      end
      @(negedge clk);
      checkOutput("single_idle_k_stall", k_stall, 1);

      // Streaming 100 pairs (i, 2i)
      clearLogs();
      for (int i = 0; i < 100; i++) applyStimulus(1, i, 2 * i, 1, 0);
      repeat (10) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("stream_accepts", accCyc.size(), 100);
      checkOutput("stream_pops", popDat.size(), 100);
      if (accCyc.size() == 100 && popDat.size() == 100) begin
         checkOutput("stream_accept_span", accCyc[99] - accCyc[0], 99);
         checkOutput("stream_first_latency", popCyc[0] - accCyc[0], 6);
         checkOutput("stream_pop_span", popCyc[99] - popCyc[0], 99);
         for (int i = 0; i < 100; i++) checkOutput("stream_data", popDat[i], 3 * i);
      end

      // Back-pressure: out_ready low for 20 cycles
      clearLogs();
      for (int i = 0; i < 20; i++) applyStimulus(1, 100 + i, i, 0, 0);
      @(negedge clk);
      checkOutput("bp_accepts", accCyc.size(), 8);
      checkOutput("bp_in_ready_full", in_ready, 0);
      checkOutput("bp_cnt_full", 32'(dut.cnt_q), 8);
      applyStimulus(0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("bp_in_ready_popcycle", in_ready, 0);
      applyStimulus(0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("bp_in_ready_after_pop", in_ready, 1);
      repeat (10) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("bp_pops", popDat.size(), 8);
      if (popDat.size() == 8) begin
         for (int i = 0; i < 8; i++) checkOutput("bp_data", popDat[i], 100 + 2 * i);
      end

      // Pause: 3 ops in flight, stall_in for 7 cycles
      clearLogs();
      for (int k = 0; k < 3; k++) applyStimulus(1, 10 + k, 1, 1, 0);
      repeat (7) applyStimulus(1, 99, 99, 1, 1);
      @(negedge clk);
      checkOutput("pause_k_stall", k_stall, 1);
      checkOutput("pause_in_ready", in_ready, 0);
      checkOutput("pause_vld_frozen", 32'(dut.vld_q), 32'b00111);
      repeat (15) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("pause_accepts", accCyc.size(), 3);
      checkOutput("pause_pops", popDat.size(), 3);
      if (popDat.size() == 3 && accCyc.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            checkOutput("pause_data", popDat[k], 11 + k);
            checkOutput("pause_latency", popCyc[k] - accCyc[k], 13);
         end
      end

      // Sparse input with randomly gated out_ready
      clearLogs();
      expQ.delete();
      for (int i = 0; i < 20; i++) begin
         if (pat[i % 5]) expQ.push_back(i + 10);
         applyStimulus(pat[i % 5], i, 10, 1'($urandom_range(0, 1)), 0);
      end
      repeat (20) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("sparse_pops", popDat.size(), expQ.size());
      if (popDat.size() == expQ.size()) begin
         foreach (expQ[k]) checkOutput("sparse_data", popDat[k], expQ[k]);
      end

      // Reset with 4 ops in the pipeline and 3 results buffered
      clearLogs();
      for (int k = 0; k < 7; k++) applyStimulus(1, k, k, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("midrst_cnt_before", 32'(dut.cnt_q), 3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_in_ready", in_ready, 0);
      checkOutput("midrst_k_stall", k_stall, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearLogs();
      repeat (3) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 5, 6, 1, 0);
      repeat (12) applyStimulus(0, 0, 0, 1, 0);
      checkOutput("midrst_pops", popDat.size(), 1);
      if (popDat.size() == 1 && accCyc.size() == 1) begin
         checkOutput("midrst_data", popDat[0], 11);
         checkOutput("midrst_latency", popCyc[0] - accCyc[0], LAT + 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kernel_chan_bridge.md
# kernel_chan_bridge

Channel-side bridge for stall-controlled kernel pipelines. It accepts operand pairs on a valid/ready input channel, drives the kernel's `stall` and operand ports, and tracks which pipeline stages hold real data. It captures kernel results into an output FIFO that drives a valid/ready output channel. Every operand accepted is guaranteed a FIFO slot before it enters the kernel, so kernel results are never dropped; it sits between host/OCL channel logic and a `kernelTop_*` instance.

## Interface
- `DATAW`, 32, operand/result width
- `LAT`, 5, kernel latency in advancing cycles (≥1)
- `DEPTH`, 8, output FIFO entries (power of 2, ≥2)

- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous active-high reset
- `stall_in` in 1, external pause; freezes kernel and blocks input
- `in_valid` in 1, operand pair valid
- `in_ready` out 1, bridge accepts operand pair this cycle
- `in_data0` in DATAW, operand 0
- `in_data1` in DATAW, operand 1
- `k_stall` out 1, to kernel `stall`
- `k_vin0` out DATAW, to kernel operand 0 (combinational from `in_data0`)
- `k_vin1` out DATAW, to kernel operand 1 (combinational from `in_data1`)
- `k_vout` in DATAW, kernel result
- `out_valid` out 1, FIFO non-empty
- `out_ready` in 1, downstream accepts
- `out_data` out DATAW, FIFO head (show-ahead)

## Operation
- `vld[LAT-1:0]` is a stage-valid shift register, and `cnt` (0..DEPTH) is the FIFO occupancy.
- `reserved = cnt + popcount(vld)`.
- `in_ready = !rst && !stall_in && (reserved < DEPTH)`.
- `accept = in_valid && in_ready`.
- `advance = !stall_in && (accept || vld != 0)`, and `k_stall = !advance`. The kernel idles when empty and freezes under `stall_in`.
- On `advance`: `vld <= {vld[LAT-2:0], accept}` (for LAT=1, `vld <= accept`).
- Push happens when `advance && vld[LAT-1]`: write `k_vout` at the write pointer. Reservation guarantees space, so a push never occurs while `cnt==DEPTH`. Bench asserts this.
- Pop happens when `out_valid && out_ready`: advance the read pointer.
- Push and pop in the same cycle leave `cnt` unchanged. Pointers wrap modulo DEPTH.
- `out_valid = (cnt != 0)`, and `out_data = mem[rd_ptr]`.
- Pop proceeds regardless of `stall_in`.
- Ordering: results leave in exactly the order operands were accepted.
- Bubble stages (`vld` bit 0) shift through without being written.

## Timing
- Reset (async assert, sync-safe deassert) sets: `vld=0`, `cnt=0`, both pointers 0, `out_valid=0`, `in_ready=0`, `k_stall=1`. FIFO contents are undefined.
- Operand latency, with no stalls:
  - accepted in cycle t → `k_vout` valid in cycle t+LAT;
  - pushed at the end of t+LAT;
  - `out_valid`/`out_data` present in cycle t+LAT+1.
- Total latency is LAT+1 cycles. Each `stall_in` cycle adds one.
- Throughput is 1 operand/cycle while `reserved < DEPTH` and `out_ready` stays high.
- `in_ready` is combinational from registered state and `stall_in`. It does not depend on `in_valid`, so there is no combinational loop.
- Pop frees a reservation in the next cycle (`cnt` updates at the edge), not in the same cycle.
- Reset mid-operation: all in-flight and buffered results are discarded. No `out_valid` is seen until new input has traversed LAT+1 cycles.

## Test plan
Bench kernel model: LAT-stage stall-able adder (`vout = vin0 + vin1`), LAT=5, DEPTH=8.

- **Single op.** Stimulus: `in_data0=3`, `in_data1=4` accepted in cycle 10, `out_ready=1`. Response: `out_valid` first high in cycle 16 with `out_data=7`. `k_stall=1` from cycle 16 onward.
- **Streaming.** Stimulus: 100 consecutive pairs `(i, 2i)`, `out_ready=1`. Response: `in_ready` stays high throughout. Outputs `3i` appear in order on 100 consecutive cycles, starting 6 cycles after the first accept.
- **Back-pressure.** Stimulus: `out_ready=0`, `in_valid=1` for 20 cycles. Response: exactly 8 accepts, then `in_ready=0`; `cnt` reaches 8 with no overflow. Then set `out_ready=1`. Response: all 8 results drain in order, and `in_ready` reasserts one cycle after the first pop.
- **Pause.** Stimulus: `stall_in=1` for 7 cycles with 3 ops in flight. Response: `k_stall=1`, `in_ready=0`, `vld` frozen. After release, the 3 results arrive in order, delayed by exactly 7 cycles.
- **Sparse input.** Stimulus: `in_valid` toggling 1,0,0,1,0 with `out_ready` randomly gated. Response: no duplicate or missing outputs. `out_valid` gaps match the input bubbles.
- **Reset mid-flight.** Stimulus: assert `rst` asynchronously with 4 ops in the pipeline and 3 in the FIFO. Response: `out_valid=0`, `in_ready=0`, `k_stall=1` immediately. After release, no stale results appear, and the next op emerges LAT+1 cycles after its accept.
